// File: rtl/control_sequencer.sv
// Mini SRC control unit: fetch T0-T2, opcode decode, and execute sequencing with
// every T-step held for STEP_CYCLES clocks. Control outputs are a Moore decode.
module control_sequencer #(
  parameter int STEP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        pc_out,
  output logic        zlo_out,
  output logic        zhi_out,
  output logic        hi_out,
  output logic        lo_out,
  output logic        mdr_out,
  output logic        inport_out,
  output logic        c_sign_extended_out,
  output logic        ba_out,
  output logic        r_out,
  output logic        mar_enable,
  output logic        z_enable,
  output logic        lo_enable,
  output logic        hi_enable,
  output logic        pc_enable,
  output logic        mdr_enable,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        r15_enable,
  output logic        r_in,
  output logic        con_enable,
  output logic        outport_enable,
  output logic        inport_enable,
  output logic        read,
  output logic        ram_write,
  output logic        pc_increment,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic [3:0]  step,
  output logic        instr_done,
  output logic        illegal_op,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_IDLE, S_HALTED
  } state_t;

  localparam logic [3:0] LAST = 4'(STEP_CYCLES - 1);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  state_t     state, next_state, final_state;
  logic [3:0] cnt;
  logic [4:0] opcode;
  logic       con_q;
  logic       supported;
  logic       last_clk;
  logic       final_step;

  // Register fields and the operand bits are consumed by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  assign last_clk   = (cnt == LAST);
  assign final_step = (state == final_state);

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      opcode <= 5'd0;
      con_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_IDLE || state == S_HALTED || last_clk) cnt <= 4'd0;
      else                                                   cnt <= cnt + 4'd1;
      if (state == S_T2 && last_clk) opcode <= ir[31:27];
      // Branch condition is captured on the edge entering T6 so it is stable all step.
      if (state == S_T5 && last_clk) con_q <= con_ff;
    end
  end

  always_comb begin
    final_state = S_T3;
    supported   = 1'b1;
    case (opcode)
      OP_LDI, OP_ADDI:                                   final_state = S_T5;
      OP_LD, OP_ST:                                      final_state = S_T7;
      OP_JAL:                                            final_state = S_T4;
      OP_BR:                                             final_state = S_T6;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT: final_state = S_T3;
      default:                                           supported   = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (run) next_state = S_T0;
      S_HALTED: next_state = S_HALTED;
      default: begin
        if (last_clk) begin
          if (!final_step)            next_state = state_t'(state + 4'd1);
          else if (opcode == OP_HALT) next_state = S_HALTED;
          else if (run)               next_state = S_T0;
          else                        next_state = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    {pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out,
     ba_out, r_out, mar_enable, z_enable, lo_enable, hi_enable, pc_enable, mdr_enable,
     ir_enable, y_enable, r15_enable, r_in, con_enable, outport_enable, inport_enable,
     read, ram_write, pc_increment, gra, grb, grc} = '0;
    case (state)
      S_T0: begin pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1; end
      S_T1: begin read = 1'b1; mdr_enable = 1'b1; zlo_out = 1'b1; pc_enable = 1'b1; end
      S_T2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
      S_T3: begin
        case (opcode)
          OP_LD, OP_LDI, OP_ST: begin grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
          OP_ADDI: begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
          OP_JR:   begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
          OP_JAL:  begin pc_out = 1'b1; r15_enable = 1'b1; end
          OP_BR:   begin gra = 1'b1; r_out = 1'b1; con_enable = 1'b1; end
          OP_IN:   begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
          OP_OUT:  begin gra = 1'b1; r_out = 1'b1; outport_enable = 1'b1; end
          OP_MFHI: begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
          OP_MFLO: begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (opcode)
          OP_LD, OP_LDI, OP_ADDI, OP_ST: begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
          OP_JAL: begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
          OP_BR:  begin pc_out = 1'b1; y_enable = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_LDI, OP_ADDI: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
          OP_LD, OP_ST:    begin zlo_out = 1'b1; mar_enable = 1'b1; end
          OP_BR:           begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_LD: begin read = 1'b1; mdr_enable = 1'b1; end
          OP_ST: begin gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1; end
          OP_BR: begin zlo_out = 1'b1; pc_enable = con_q; end
          default: ;
        endcase
      end
      S_T7: begin
        case (opcode)
          OP_LD: begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
          OP_ST: ram_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign step       = (state == S_IDLE || state == S_HALTED) ? 4'hF : 4'(state);
  assign instr_done = final_step && last_clk;
  assign illegal_op = (state == S_T3) && (cnt == 4'd0) && !supported;
  assign halted     = (state == S_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a STEP_CYCLES=2 unit runs the main program,
// a STEP_CYCLES=1 unit runs the single-cycle store.
module tb_control_sequencer;

  localparam logic [28:0] PC_OUT = 29'h1 << 28, ZLO_OUT = 29'h1 << 27, ZHI_OUT = 29'h1 << 26;
  localparam logic [28:0] HI_OUT = 29'h1 << 25, LO_OUT = 29'h1 << 24, MDR_OUT = 29'h1 << 23;
  localparam logic [28:0] INPORT_OUT = 29'h1 << 22, CSE_OUT = 29'h1 << 21, BA_OUT = 29'h1 << 20;
  localparam logic [28:0] R_OUT = 29'h1 << 19, MAR_EN = 29'h1 << 18, Z_EN = 29'h1 << 17;
  localparam logic [28:0] PC_EN = 29'h1 << 14, MDR_EN = 29'h1 << 13, IR_EN = 29'h1 << 12;
  localparam logic [28:0] Y_EN = 29'h1 << 11, R15_EN = 29'h1 << 10, R_IN = 29'h1 << 9;
  localparam logic [28:0] CON_EN = 29'h1 << 8, READ = 29'h1 << 5, RAM_WRITE = 29'h1 << 4;
  localparam logic [28:0] PC_INC = 29'h1 << 3, GRA = 29'h1 << 2, GRB = 29'h1 << 1;

  localparam logic [28:0] F0 = PC_OUT | MAR_EN | PC_INC | Z_EN;
  localparam logic [28:0] F1 = READ | MDR_EN | ZLO_OUT | PC_EN;
  localparam logic [28:0] F2 = MDR_OUT | IR_EN;

  logic        clk = 1'b0;
  logic        clr, run, con_ff, clr1, run1;
  logic [31:0] ir, ir1;
  logic [28:0] ctl, ctl1;
  logic [3:0]  step, step1;
  logic        done, done1, ill, ill1, hlt, hlt1;
  logic [28:0] e [8];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  control_sequencer #(.STEP_CYCLES(2)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .con_ff(con_ff),
    .pc_out(ctl[28]), .zlo_out(ctl[27]), .zhi_out(ctl[26]), .hi_out(ctl[25]), .lo_out(ctl[24]),
    .mdr_out(ctl[23]), .inport_out(ctl[22]), .c_sign_extended_out(ctl[21]), .ba_out(ctl[20]),
    .r_out(ctl[19]), .mar_enable(ctl[18]), .z_enable(ctl[17]), .lo_enable(ctl[16]),
    .hi_enable(ctl[15]), .pc_enable(ctl[14]), .mdr_enable(ctl[13]), .ir_enable(ctl[12]),
    .y_enable(ctl[11]), .r15_enable(ctl[10]), .r_in(ctl[9]), .con_enable(ctl[8]),
    .outport_enable(ctl[7]), .inport_enable(ctl[6]), .read(ctl[5]), .ram_write(ctl[4]),
    .pc_increment(ctl[3]), .gra(ctl[2]), .grb(ctl[1]), .grc(ctl[0]),
    .step(step), .instr_done(done), .illegal_op(ill), .halted(hlt)
  );

  control_sequencer #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .clr(clr1), .run(run1), .ir(ir1), .con_ff(con_ff),
    .pc_out(ctl1[28]), .zlo_out(ctl1[27]), .zhi_out(ctl1[26]), .hi_out(ctl1[25]), .lo_out(ctl1[24]),
    .mdr_out(ctl1[23]), .inport_out(ctl1[22]), .c_sign_extended_out(ctl1[21]), .ba_out(ctl1[20]),
    .r_out(ctl1[19]), .mar_enable(ctl1[18]), .z_enable(ctl1[17]), .lo_enable(ctl1[16]),
    .hi_enable(ctl1[15]), .pc_enable(ctl1[14]), .mdr_enable(ctl1[13]), .ir_enable(ctl1[12]),
    .y_enable(ctl1[11]), .r15_enable(ctl1[10]), .r_in(ctl1[9]), .con_enable(ctl1[8]),
    .outport_enable(ctl1[7]), .inport_enable(ctl1[6]), .read(ctl1[5]), .ram_write(ctl1[4]),
    .pc_increment(ctl1[3]), .gra(ctl1[2]), .grb(ctl1[1]), .grc(ctl1[0]),
    .step(step1), .instr_done(done1), .illegal_op(ill1), .halted(hlt1)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps through one instruction clock by clock, starting at the edge that enters T0.
  task automatic apply_stimulus(input string tag, input bit fast, input logic [28:0] exp [8],
                                input int nsteps, input int limit, input bit illegal);
    int sc;
    int s;
    sc = fast ? 1 : 2;
    for (int c = 0; c < nsteps * sc && c < limit; c++) begin
      @(negedge clk);
      s = c / sc;
      check_output({tag, " step"}, fast ? step1 : step, s);
      check_output({tag, " ctl"}, fast ? ctl1 : ctl, exp[s]);
      check_output({tag, " done"}, fast ? done1 : done, (c == nsteps * sc - 1));
      check_output({tag, " illegal"}, fast ? ill1 : ill, (illegal && s == 3 && (c % sc) == 0));
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_halted);
    check_output({tag, " step"}, step, 4'hF);
    check_output({tag, " ctl"}, ctl, 29'h0);
    check_output({tag, " done"}, done, 1'b0);
    check_output({tag, " illegal"}, ill, 1'b0);
    check_output({tag, " halted"}, hlt, exp_halted);
  endtask

  initial begin
    clr = 1'b1; run = 1'b0; ir = 32'h0; con_ff = 1'b0;
    clr1 = 1'b1; run1 = 1'b0; ir1 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset", 1'b0);

    // ldi R3,0x65 from idle; ir changes after the latch must not matter
    clr = 1'b0; run = 1'b1; ir = 32'h0980_0065;
    e = '{F0, F1, F2, GRB | BA_OUT | Y_EN, CSE_OUT | Z_EN, ZLO_OUT | GRA | R_IN, 29'h0, 29'h0};
    apply_stimulus("ldi", 1'b0, e, 6, 100, 1'b0);

    ir = 32'h9980_0000;
    e = '{F0, F1, F2, GRA | R_OUT | PC_EN, 29'h0, 29'h0, 29'h0, 29'h0};
    apply_stimulus("jr", 1'b0, e, 4, 100, 1'b0);

    ir = 32'h9000_0000; con_ff = 1'b0;
    e = '{F0, F1, F2, GRA | R_OUT | CON_EN, PC_OUT | Y_EN, CSE_OUT | Z_EN, ZLO_OUT, 29'h0};
    apply_stimulus("br_nt", 1'b0, e, 7, 100, 1'b0);

    con_ff = 1'b1;
    e = '{F0, F1, F2, GRA | R_OUT | CON_EN, PC_OUT | Y_EN, CSE_OUT | Z_EN, ZLO_OUT | PC_EN, 29'h0};
    apply_stimulus("br_t", 1'b0, e, 7, 100, 1'b0);
    con_ff = 1'b0;

    ir = 32'hF800_0000;
    e = '{F0, F1, F2, 29'h0, 29'h0, 29'h0, 29'h0, 29'h0};
    apply_stimulus("illegal", 1'b0, e, 4, 100, 1'b1);

    ir = 32'hD000_0000;
    apply_stimulus("halt", 1'b0, e, 4, 100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("halted", 1'b1);
    end

    clr = 1'b1;
    @(negedge clk);
    check_idle("clr_halt", 1'b0);

    // ld abandoned by clr on the first clock of T6
    clr = 1'b0; ir = 32'h0180_0004;
    e = '{F0, F1, F2, GRB | BA_OUT | Y_EN, CSE_OUT | Z_EN, ZLO_OUT | MAR_EN, READ | MDR_EN,
          MDR_OUT | GRA | R_IN};
    apply_stimulus("ld", 1'b0, e, 8, 13, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    check_idle("clr_ld", 1'b0);
    clr = 1'b0;
    @(negedge clk);
    check_output("restart step", step, 4'd0);
    check_output("restart ctl", ctl, F0);

    // st on the single-cycle unit
    clr1 = 1'b0; run1 = 1'b1; ir1 = 32'h1000_0000;
    e = '{F0, F1, F2, GRB | BA_OUT | Y_EN, CSE_OUT | Z_EN, ZLO_OUT | MAR_EN, GRA | R_OUT | MDR_EN,
          RAM_WRITE};
    apply_stimulus("st1", 1'b1, e, 8, 100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised Mini SRC control unit that replaces hand-sequenced T-state stimulus for the `datapath`. It runs the fetch steps T0–T2, decodes the opcode in `ir[31:27]`, and sequences the execute steps of the supported instruction subset. Its outputs are the `datapath` control inputs, port-for-port. Each T-step is held for `STEP_CYCLES` clocks, which keeps the slow-step timing used on the bench while allowing single-cycle steps once the datapath closes timing.

## Interface
- `STEP_CYCLES`, default 2: clocks each T-step is held; legal range 1–15.
- `clk` in 1: single clock, rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `run` in 1: 1 allows a new fetch to start; sampled only at the T0 boundary.
- `ir` in 32: IR contents from the datapath. Field layout:
  - opcode `[31:27]`
  - ra `[26:23]`
  - rb `[22:19]`
- `con_ff` in 1: CON FF value from the datapath (`con_out`).
- Control outputs, each 1 bit, same names as the `datapath` ports:
  - `pc_out`, `zlo_out`, `zhi_out`, `hi_out`, `lo_out`, `mdr_out`, `inport_out`, `c_sign_extended_out`, `ba_out`, `r_out`
  - `mar_enable`, `z_enable`, `lo_enable`, `hi_enable`, `pc_enable`, `mdr_enable`, `ir_enable`, `y_enable`, `r15_enable`, `r_in`, `con_enable`, `outport_enable`, `inport_enable`
  - `read`, `ram_write`, `pc_increment`, `gra`, `grb`, `grc`
- `step` out 4: current T-step index; 0xF while idle or halted.
- `instr_done` out 1: one-cycle pulse on the last clock of an instruction's final step.
- `illegal_op` out 1: one-cycle pulse on the first clock of T3 when the opcode is unsupported.
- `halted` out 1: level; 1 after `halt` until `clr`.

## Operation
- **Output structure:** Moore machine. Control outputs are a pure decode of the registered state and the latched opcode. Any output not listed for a step is 0.
- **States:** IDLE, T0–T7, HALTED.
- **Opcode latch:** loaded from `ir[31:27]` on the last clock of T2. Changes on `ir` after that are ignored until the next fetch.
- **Fetch (all instructions):**
  - T0: `pc_out`, `mar_enable`, `pc_increment`, `z_enable`.
  - T1: `read`, `mdr_enable`, `zlo_out`, `pc_enable`.
  - T2: `mdr_out`, `ir_enable`.
- **Execute steps:**
  - ldi 00001:
    - T3 `grb` `ba_out` `y_enable`
    - T4 `c_sign_extended_out` `z_enable`
    - T5 `zlo_out` `gra` `r_in`
  - addi 01011: same as ldi, except T3 uses `r_out` in place of `ba_out`.
  - ld 00000: T3–T4 as ldi, then:
    - T5 `zlo_out` `mar_enable`
    - T6 `read` `mdr_enable`
    - T7 `mdr_out` `gra` `r_in`
  - st 00010: T3–T5 as ld, then:
    - T6 `gra` `r_out` `mdr_enable` (`read`=0)
    - T7 `ram_write`
  - jr 10011: T3 `gra` `r_out` `pc_enable`.
  - jal 10100:
    - T3 `pc_out` `r15_enable`
    - T4 `gra` `r_out` `pc_enable`
  - branch 10010:
    - T3 `gra` `r_out` `con_enable`
    - T4 `pc_out` `y_enable`
    - T5 `c_sign_extended_out` `z_enable`
    - T6 `zlo_out`, plus `pc_enable` only if `con_ff`=1; `con_ff` is sampled on the first clock of T6 and held through T6.
  - Single-step instructions, all at T3:
    - in 10101: `inport_out` `gra` `r_in`
    - out 10110: `gra` `r_out` `outport_enable`
    - mfhi 10111: `hi_out` `gra` `r_in`
    - mflo 11000: `lo_out` `gra` `r_in`
  - nop 11001: single empty step T3.
  - halt 11010: T3 empty, then HALTED.
- **Unsupported opcodes** (including the reg-reg ALU ops in this version): `illegal_op` pulses and the instruction executes as nop.
- **Transitions:**
  - IDLE→T0 when `run`=1.
  - After each instruction's final step: →T0 if `run`=1, else →IDLE.
  - HALTED is exited only by `clr`.

## Timing
- **Reset:** `clr`=1 at a rising edge puts the machine in IDLE with all control outputs 0, `step`=0xF, `instr_done`=0, `illegal_op`=0 and `halted`=0. Any instruction in progress is abandoned: no further strobes, and `ram_write` drops on that same edge.
- **Step counter:** counts 0..`STEP_CYCLES`−1. The state advances on the edge where the counter equals `STEP_CYCLES`−1.
- **Output timing:** outputs change only on clock edges and are stable for all `STEP_CYCLES` clocks of a step.
- **Instruction latency:** (number of steps) × `STEP_CYCLES` clocks, from the first clock of T0 to the end of the final step.
  - ldi = 6 steps.
  - ld = 8 steps.
  - jr = 4 steps.
- **Back-to-back:** with `run` held at 1, the next T0 follows the final step on the very next clock, with no gap cycle.
- **Idle start:** IDLE→T0 takes one clock after `run` rises.
- **`run` changes:** a fall of `run` mid-instruction has no effect until the instruction completes.
- **`STEP_CYCLES`=1:** every step is one clock and `instr_done` coincides with the final step.

## Test plan
- Reset, then ldi R3,0x65: `STEP_CYCLES`=2, `ir`=0x0980_0065, `run`=1. Required response:
  - `step` goes 0..5, each for 2 clocks.
  - T3 asserts `grb`/`ba_out`/`y_enable`.
  - T5 asserts `zlo_out`/`gra`/`r_in`.
  - `instr_done` pulses at clock 12.
- jr R3 after ldi: `ir`=0x9980_0000 at T2. Required: T3 asserts `gra`+`r_out`+`pc_enable` for 2 clocks; next T0 starts with no gap.
- Branch both ways: branch with `con_ff`=0, then with `con_ff`=1. Required: T6 asserts `zlo_out` in both cases; `pc_enable` is 0 in the first case and 1 in the second.
- st with `STEP_CYCLES`=1: required 8 steps over 8 clocks; `ram_write` high only on clock 8; `read` never high at T6.
- Illegal opcode then halt: opcode 11111, then `ir`=0xD000_0000. Required:
  - `illegal_op` pulses once and the instruction completes as a 4-step nop.
  - halt sets `halted`=1 with all control outputs 0 until `clr`.
- `clr` mid-ld during T6: required next edge gives IDLE with all outputs 0; after `clr` releases with `run`=1, T0 follows one clock later.
